vend_sched: RTL and testbench

VEND_SCHED -- requirements
Module: vend_sched

---
 rtl/vend_sched.sv | 199 +++++++++++++++++++
 tb/tb_vend_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_sched.sv
// Round-robin coin scheduler for a shared vending engine.
// Optional stats counters: define VEND_SCHED_STATS_EN.
module vend_sched #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned GAP     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [7:0] mode,
  output logic [3:0] gnt,
  output logic [1:0] coin,
  input  logic       eng_vld,
  input  logic [1:0] eng_chg,
  output logic [3:0] done,
  output logic       chg,
  output logic       err,
  output logic       busy
`ifdef VEND_SCHED_STATS_EN
  ,
  output logic [15:0] vend_cnt,
  output logic [7:0]  err_cnt
`endif
);

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_COIN = 5'b00010,
    S_GAP  = 5'b00100,
    S_WAIT = 5'b01000,
    S_DONE = 5'b10000
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] own_q, own_d;
  logic [1:0] md_q, md_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] last_q, last_d;
  logic [2:0] gcnt_q, gcnt_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       chg_q, chg_d;
  logic       err_q, err_d;

  logic [1:0] code;
  logic       fin;
  logic [1:0] pick;
  logic [1:0] cand;
  logic       hit;

  always_comb begin
    code = 2'd0;
    case (md_q)
      2'd0:    code = 2'd1;
      2'd1:    code = (idx_q == 2'd0) ? 2'd1 : 2'd2;
      2'd2:    code = (idx_q == 2'd0) ? 2'd2 : 2'd1;
      default: code = 2'd2;
    endcase
    fin = (idx_q == ((md_q == 2'd0) ? 2'd2 : 2'd1));
  end

  always_comb begin
    pick = last_q;
    cand = 2'd0;
    hit  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!hit && req[cand]) begin
        pick = cand;
        hit  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    md_d    = md_q;
    idx_d   = idx_q;
    last_d  = last_q;
    gcnt_d  = gcnt_q;
    wcnt_d  = wcnt_q;
    chg_d   = chg_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          own_d   = pick;
          md_d    = 2'(mode >> {pick, 1'b0});
          idx_d   = 2'd0;
          state_d = S_COIN;
        end
      end
      S_COIN: begin
        if (eng_vld) begin
          err_d   = 1'b1;
          last_d  = own_q;
          state_d = S_IDLE;
        end else if (fin) begin
          wcnt_d  = 8'd0;
          state_d = S_WAIT;
        end else begin
          idx_d = idx_q + 2'd1;
          if (GAP == 0) begin
            state_d = S_COIN;
          end else begin
            gcnt_d  = 3'd0;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (eng_vld) begin
          err_d   = 1'b1;
          last_d  = own_q;
          state_d = S_IDLE;
        end else if (gcnt_q == 3'(GAP - 1)) begin
          state_d = S_COIN;
        end else begin
          gcnt_d = gcnt_q + 3'd1;
        end
      end
      S_WAIT: begin
        if (eng_vld) begin
          chg_d   = |eng_chg;
          state_d = S_DONE;
        end else if (wcnt_q == 8'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          last_d  = own_q;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      S_DONE: begin
        last_d  = own_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      own_q   <= 2'd0;
      md_q    <= 2'd0;
      idx_q   <= 2'd0;
      last_q  <= 2'd3;
      gcnt_q  <= 3'd0;
      wcnt_q  <= 8'd0;
      chg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      md_q    <= md_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      gcnt_q  <= gcnt_d;
      wcnt_q  <= wcnt_d;
      chg_q   <= chg_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode registered state only, so reset clears them at once.
  assign busy = (state_q != S_IDLE);
  assign gnt  = busy ? (4'b0001 << own_q) : 4'b0000;
  assign coin = (state_q == S_COIN) ? code : 2'd0;
  assign done = (state_q == S_DONE) ? (4'b0001 << own_q) : 4'b0000;
  assign chg  = (state_q == S_DONE) && chg_q;
  assign err  = err_q;

`ifdef VEND_SCHED_STATS_EN
  logic [15:0] vcnt_q, vcnt_d;
  logic [7:0]  ecnt_q, ecnt_d;

  always_comb begin
    vcnt_d = vcnt_q;
    ecnt_d = ecnt_q;
    if (state_q == S_DONE && vcnt_q != 16'hFFFF) vcnt_d = vcnt_q + 16'd1;
    if (err_q && ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vcnt_q <= 16'd0;
      ecnt_q <= 8'd0;
    end else begin
      vcnt_q <= vcnt_d;
      ecnt_q <= ecnt_d;
    end
  end

  assign vend_cnt = vcnt_q;
  assign err_cnt  = ecnt_q;
`endif

endmodule

// File: tb/tb_vend_sched.sv
// Randomized bench for vend_sched against a transaction-level model.
// Stats counters are checked when VEND_SCHED_STATS_EN is defined.
module tb_vend_sched;

  localparam int TO = 15;
  localparam int GP = 1;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] mode;
  logic [3:0] gnt;
  logic [1:0] coin;
  logic       eng_vld;
  logic [1:0] eng_chg;
  logic [3:0] done;
  logic       chg;
  logic       err;
  logic       busy;
`ifdef VEND_SCHED_STATS_EN
  logic [15:0] vend_cnt;
  logic [7:0]  err_cnt;
`endif

  vend_sched #(.TIMEOUT(TO), .GAP(GP)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .mode    (mode),
    .gnt     (gnt),
    .coin    (coin),
    .eng_vld (eng_vld),
    .eng_chg (eng_chg),
    .done    (done),
    .chg     (chg),
    .err     (err),
    .busy    (busy)
`ifdef VEND_SCHED_STATS_EN
    ,
    .vend_cnt(vend_cnt),
    .err_cnt (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  int cyc_n;

  // reference model state
  int         last_own;
  logic       err_pend;
  int         vends;
  int         errs;
  logic [3:0] obs_gnt;

  // coin table: row = mode, column = coin position
  int tbl [4][3] = '{'{1, 1, 1}, '{1, 2, 0}, '{2, 1, 0}, '{2, 2, 0}};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               tag, cyc_n, got, exp);
    end
  endtask

  // check outputs of the current cycle, then drive its inputs
  task automatic cyc(input logic [3:0] eg, input logic [1:0] ec,
                     input logic [3:0] ed, input logic eh,
                     input logic ee, input logic eb,
                     input logic [3:0] rq, input logic [7:0] md,
                     input logic v, input logic [1:0] ch);
    chk("gnt", 32'(gnt), 32'(eg));
    chk("coin", 32'(coin), 32'(ec));
    chk("done", 32'(done), 32'(ed));
    chk("chg", 32'(chg), 32'(eh));
    chk("err", 32'(err), 32'(ee));
    chk("busy", 32'(busy), 32'(eb));
    req     = rq;
    mode    = md;
    eng_vld = v;
    eng_chg = ch;
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic idle_cyc(input logic [3:0] rq, input logic [7:0] md);
    cyc(4'd0, 2'd0, 4'd0, 1'b0, err_pend, 1'b0,
        rq, md, 1'b0, 2'($urandom));
    err_pend = 1'b0;
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) idle_cyc(4'd0, 8'($urandom));
  endtask

  // kind: 0 = engine answers after dly WAIT cycles, 1 = timeout,
  //       2 = eng_vld during coin phase cycle pe (mod length)
  task automatic run_txn(input logic [3:0] rq, input logic [7:0] md,
                         input int kind, input int dly,
                         input logic [1:0] ech, input int pe,
                         input int idle_n);
    int own;
    int om;
    int n;
    int ph[$];
    logic [3:0] g;
    logic v;
    for (int i = 0; i < idle_n; i++) idle_cyc(4'd0, 8'($urandom));
    own = -1;
    for (int i = 1; i <= 4; i++) begin
      if (own < 0 && rq[(last_own + i) % 4]) own = (last_own + i) % 4;
    end
    om = int'((md >> (2 * own)) & 8'h3);
    g  = 4'(1 << own);
    n  = (om == 0) ? 3 : 2;
    ph = {};
    for (int k = 0; k < n; k++) begin
      ph.push_back(tbl[om][k]);
      if (k < n - 1) for (int z = 0; z < GP; z++) ph.push_back(0);
    end
    idle_cyc(rq, md);
    for (int j = 0; j < ph.size(); j++) begin
      v = (kind == 2) && (j == pe % ph.size());
      if (j == 0) obs_gnt = gnt;
      cyc(g, 2'(ph[j]), 4'd0, 1'b0, 1'b0, 1'b1,
          4'($urandom), 8'($urandom), v, 2'($urandom));
      if (v) begin
        last_own = own;
        err_pend = 1'b1;
        errs = (errs < 255) ? errs + 1 : 255;
        return;
      end
    end
    if (kind == 1) begin
      for (int w = 0; w < TO; w++)
        cyc(g, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1,
            4'($urandom), 8'($urandom), 1'b0, 2'($urandom));
      last_own = own;
      err_pend = 1'b1;
      errs = (errs < 255) ? errs + 1 : 255;
      return;
    end
    for (int w = 0; w <= dly; w++)
      cyc(g, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1,
          4'($urandom), 8'($urandom), (w == dly),
          (w == dly) ? ech : 2'($urandom));
    cyc(g, 2'd0, g, |ech, 1'b0, 1'b1,
        4'($urandom), 8'($urandom), 1'b0, 2'($urandom));
    last_own = own;
    vends = (vends < 65535) ? vends + 1 : 65535;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    last_own = 3;
    err_pend = 1'b0;
    vends    = 0;
    errs     = 0;
  endtask

  initial begin
    int r;
    n_chk    = 0;
    n_fail   = 0;
    cyc_n    = 0;
    last_own = 3;
    err_pend = 1'b0;
    vends    = 0;
    errs     = 0;
    rst_n    = 1'b0;
    req      = 4'd0;
    mode     = 8'd0;
    eng_vld  = 1'b0;
    eng_chg  = 2'd0;
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_coin", 32'(coin), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    // all four requesting, mode 3, change returned each time
    for (int i = 0; i < 4; i++) begin
      run_txn(4'hF, 8'hFF, 0, int'($urandom_range(0, 3)), 2'b01, 0, 0);
      chk("rr_order", 32'(obs_gnt), 32'(1 << i));
    end
    // mode 0 single requester: coins 1,0,1,0,1
    run_txn(4'b0001, 8'h00, 0, 0, 2'b00, 0, 1);
    // timeout, then idle with busy low
    run_txn(4'b0100, 8'h10, 1, 0, 2'b00, 0, 0);
    flush(2);
    // eng_vld in first GAP cycle
    run_txn(4'b0001, 8'h00, 2, 0, 2'b00, 1, 0);
    flush(1);
    // answer on the final WAIT cycle still vends
    run_txn(4'b1000, 8'h40, 0, TO - 1, 2'b10, 0, 0);

    for (int t = 0; t < 200; t++) begin
      r = int'($urandom_range(0, 99));
      run_txn(4'($urandom_range(1, 15)), 8'($urandom),
              (r < 70) ? 0 : ((r < 85) ? 1 : 2),
              int'($urandom_range(0, TO - 1)), 2'($urandom),
              int'($urandom_range(0, 99)), int'($urandom_range(0, 2)));
    end
    flush(2);
`ifdef VEND_SCHED_STATS_EN
    chk("vend_cnt_rand", 32'(vend_cnt), 32'(vends));
    chk("err_cnt_rand", 32'(err_cnt), 32'(errs));
`endif

    // reset during the second coin of mode 0
    idle_cyc(4'b0001, 8'h00);
    cyc(4'b0001, 2'd1, 4'd0, 1'b0, 1'b0, 1'b1,
        4'b0001, 8'h00, 1'b0, 2'd0);
    cyc(4'b0001, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1,
        4'b0001, 8'h00, 1'b0, 2'd0);
    chk("pre_rst_coin", 32'(coin), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_coin", 32'(coin), 32'd0);
    chk("async_gnt", 32'(gnt), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err2", 32'(err), 32'd0);
    rst_n    = 1'b1;
    last_own = 3;
    err_pend = 1'b0;
    vends    = 0;
    errs     = 0;
    run_txn(4'b0001, 8'h00, 0, 1, 2'b00, 0, 0);
    flush(1);

    // three good vends and one timeout from a clean reset
    do_reset();
    for (int i = 0; i < 3; i++)
      run_txn(4'($urandom_range(1, 15)), 8'($urandom), 0,
              int'($urandom_range(0, 4)), 2'($urandom), 0, 0);
    run_txn(4'b0010, 8'h00, 1, 0, 2'b00, 0, 0);
    flush(2);
`ifdef VEND_SCHED_STATS_EN
    chk("vend_cnt", 32'(vend_cnt), 32'd3);
    chk("err_cnt", 32'(err_cnt), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
